// File: rtl/oversample_filter_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : oversample_filter_pkg                                   |
// | Brief  : Shared host endpoint addresses and host-command decode  |
// |          type for the oversample (boxcar decimation) filter.     |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
package oversample_filter_pkg;

  // Host write endpoints owned by the oversample filter
  localparam logic [15:0] OS_RATIO_ADDR    = 16'h0040;
  localparam logic [15:0] OS_CLR_RQST_ADDR = 16'h0041;

  // Decoded host request for the current cycle
  typedef enum logic [1:0] {
    HOST_NOP   = 2'd0,
    HOST_RATIO = 2'd1,
    HOST_CLEAR = 2'd2
  } host_cmd_e;

endpackage
`default_nettype wire

// File: rtl/os_chan_mem.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : os_chan_mem                                             |
// | Brief  : Per-channel running sum / sample count store with one   |
// |          registered read port, one accumulate write port, a      |
// |          channel clear port and a write->read bypass so a read   |
// |          issued in the same cycle as a write sees the new value. |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module os_chan_mem #(
  parameter int N_CHAN = 8,
  parameter int W_IDX  = 3,
  parameter int W_SUM  = 33,
  parameter int W_CNT  = 15
) (
  input  logic             clk_in,
  input  logic             rst_in,
  // registered read (fetch stage)
  input  logic [W_IDX-1:0] rd_idx,
  output logic [W_SUM-1:0] rd_sum,
  output logic [W_CNT-1:0] rd_cnt,
  // accumulate writeback
  input  logic             wr_en,
  input  logic [W_IDX-1:0] wr_idx,
  input  logic [W_SUM-1:0] wr_sum,
  input  logic [W_CNT-1:0] wr_cnt,
  // channel clear, takes priority over a writeback to the same channel
  input  logic             clr_en,
  input  logic [W_IDX-1:0] clr_idx
);

  logic [W_SUM-1:0] r_sum_mem [N_CHAN];
  logic [W_CNT-1:0] r_cnt_mem [N_CHAN];
  logic [W_SUM-1:0] r_rd_sum;
  logic [W_CNT-1:0] r_rd_cnt;

  // Storage update: writeback first, clear last so the clear wins on a collision
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < N_CHAN; i++) begin
        r_sum_mem[i] <= '0;
        r_cnt_mem[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        r_sum_mem[wr_idx] <= wr_sum;
        r_cnt_mem[wr_idx] <= wr_cnt;
      end
      if (clr_en) begin
        r_sum_mem[clr_idx] <= '0;
        r_cnt_mem[clr_idx] <= '0;
      end
    end
  end

  // Registered read with bypass of whatever is being written this same cycle
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_rd_sum <= '0;
      r_rd_cnt <= '0;
    end else if (clr_en && (clr_idx == rd_idx)) begin
      r_rd_sum <= '0;
      r_rd_cnt <= '0;
    end else if (wr_en && (wr_idx == rd_idx)) begin
      r_rd_sum <= wr_sum;
      r_rd_cnt <= wr_cnt;
    end else begin
      r_rd_sum <= r_sum_mem[rd_idx];
      r_rd_cnt <= r_cnt_mem[rd_idx];
    end
  end

  assign rd_sum = r_rd_sum;
  assign rd_cnt = r_rd_cnt;

endmodule
`default_nettype wire

// File: rtl/oversample_filter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : oversample_filter                                       |
// | Brief  : Per-channel boxcar decimator. Accumulates 2^os samples  |
// |          per channel from a time-multiplexed dv/chan/data stream |
// |          and emits their floor average in the same format.       |
// |          Two pipe stages: fetch (P1) and accumulate/emit (P2).   |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module oversample_filter
  import oversample_filter_pkg::*;
#(
  parameter int W_CHAN    = 5,
  parameter int N_CHAN    = 8,
  parameter int W_DIN     = 18,
  parameter int MAX_OS    = 15,
  parameter int W_WR_ADDR = 16,
  parameter int W_WR_CHAN = 16,
  parameter int W_WR_DATA = 48
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    dv_in,
  input  logic [W_CHAN-1:0]       chan_in,
  input  logic signed [W_DIN-1:0] data_in,
  input  logic                    wr_en,
  input  logic [W_WR_ADDR-1:0]    wr_addr,
  input  logic [W_WR_CHAN-1:0]    wr_chan,
  input  logic [W_WR_DATA-1:0]    wr_data,
  output logic                    dv_out,
  output logic [W_CHAN-1:0]       chan_out,
  output logic signed [W_DIN-1:0] data_out
);

  localparam int W_SUM = W_DIN + MAX_OS;
  localparam int W_OS  = $clog2(MAX_OS + 1);
  localparam int W_IDX = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;
  localparam logic [MAX_OS-1:0] CNT_ONES = {MAX_OS{1'b1}};

  // ---------------------------------------------------------------- host
  host_cmd_e        w_cmd;
  logic             w_wr_chan_ok;
  logic             w_clr;
  logic [W_IDX-1:0] w_wr_idx;
  logic [W_OS-1:0]  w_os_req;

  assign w_wr_chan_ok = ({1'b0, wr_chan} < (W_WR_CHAN + 1)'(N_CHAN));
  assign w_wr_idx     = wr_chan[W_IDX-1:0];
  // A ratio write restarts the channel, so it clears exactly like a clear request
  assign w_clr        = (w_cmd != HOST_NOP);

  // Decode the host write into a ratio update, a clear or nothing
  always_comb begin
    w_cmd = HOST_NOP;
    if (wr_en && w_wr_chan_ok) begin
      if (wr_addr == W_WR_ADDR'(OS_RATIO_ADDR)) begin
        w_cmd = HOST_RATIO;
      end else if ((wr_addr == W_WR_ADDR'(OS_CLR_RQST_ADDR)) && wr_data[0]) begin
        w_cmd = HOST_CLEAR;
      end
    end
  end

  // Saturate the whole requested ratio so out-of-range requests land on MAX_OS
  always_comb begin
    w_os_req = wr_data[W_OS-1:0];
    if (wr_data > W_WR_DATA'(MAX_OS)) begin
      w_os_req = W_OS'(MAX_OS);
    end
  end

  logic [W_OS-1:0] r_os_mem [N_CHAN];

  // Per-channel log2 ratio; zero after reset means pass-through
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < N_CHAN; i++) begin
        r_os_mem[i] <= '0;
      end
    end else if (w_cmd == HOST_RATIO) begin
      r_os_mem[w_wr_idx] <= w_os_req;
    end
  end

  // ---------------------------------------------------------------- P1
  logic             w_in_chan_ok;
  logic             w_in_take;
  logic [W_IDX-1:0] w_in_idx;

  assign w_in_chan_ok = ({1'b0, chan_in} < (W_CHAN + 1)'(N_CHAN));
  assign w_in_idx     = chan_in[W_IDX-1:0];
  // Out-of-range channels are dropped; a sample colliding with a clear is lost
  assign w_in_take    = dv_in && w_in_chan_ok && !(w_clr && (w_wr_idx == w_in_idx));

  logic                    r_p1_dv;
  logic [W_CHAN-1:0]       r_p1_chan;
  logic signed [W_DIN-1:0] r_p1_data;
  logic [W_OS-1:0]         r_p1_os;

  // Fetch stage: capture the sample and its channel ratio
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_p1_dv   <= 1'b0;
      r_p1_chan <= '0;
      r_p1_data <= '0;
      r_p1_os   <= '0;
    end else begin
      r_p1_dv <= w_in_take;
      if (w_in_take) begin
        r_p1_chan <= chan_in;
        r_p1_data <= data_in;
        r_p1_os   <= r_os_mem[w_in_idx];
      end
    end
  end

  // ---------------------------------------------------------------- P2
  logic [W_SUM-1:0]        w_rd_sum;
  logic [MAX_OS-1:0]       w_rd_cnt;
  logic [W_IDX-1:0]        w_p1_idx;
  logic                    w_p2_kill;
  logic                    w_p2_go;
  logic signed [W_SUM-1:0] w_sum_next;
  logic [MAX_OS-1:0]       w_cnt_next;
  logic [MAX_OS-1:0]       w_cnt_lim;
  logic                    w_last;
  logic signed [W_DIN-1:0] w_avg;
  logic [W_SUM-1:0]        w_wb_sum;
  logic [MAX_OS-1:0]       w_wb_cnt;

  assign w_p1_idx   = r_p1_chan[W_IDX-1:0];
  assign w_p2_kill  = w_clr && (w_wr_idx == w_p1_idx);
  assign w_p2_go    = r_p1_dv && !w_p2_kill;
  assign w_sum_next = $signed(w_rd_sum) + $signed({{MAX_OS{r_p1_data[W_DIN-1]}}, r_p1_data});
  assign w_cnt_next = w_rd_cnt + 1'b1;
  // Block is complete when the count already holds 2^os - 1 earlier samples
  assign w_cnt_lim  = CNT_ONES >> (W_OS'(MAX_OS) - r_p1_os);
  assign w_last     = (w_rd_cnt == w_cnt_lim);
  // Arithmetic shift floors toward minus infinity; result always fits W_DIN
  assign w_avg      = W_DIN'(w_sum_next >>> r_p1_os);
  assign w_wb_sum   = w_last ? '0 : w_sum_next;
  assign w_wb_cnt   = w_last ? '0 : w_cnt_next;

  os_chan_mem #(
    .N_CHAN (N_CHAN),
    .W_IDX  (W_IDX),
    .W_SUM  (W_SUM),
    .W_CNT  (MAX_OS)
  ) u_chan_mem (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .rd_idx  (w_in_idx),
    .rd_sum  (w_rd_sum),
    .rd_cnt  (w_rd_cnt),
    .wr_en   (w_p2_go),
    .wr_idx  (w_p1_idx),
    .wr_sum  (w_wb_sum),
    .wr_cnt  (w_wb_cnt),
    .clr_en  (w_clr),
    .clr_idx (w_wr_idx)
  );

  logic                    r_dv_out;
  logic [W_CHAN-1:0]       r_chan_out;
  logic signed [W_DIN-1:0] r_data_out;

  // Emit stage: strobe on block completion, hold channel/data otherwise
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_dv_out   <= 1'b0;
      r_chan_out <= '0;
      r_data_out <= '0;
    end else begin
      r_dv_out <= w_p2_go && w_last;
      if (w_p2_go && w_last) begin
        r_chan_out <= r_p1_chan;
        r_data_out <= w_avg;
      end
    end
  end

  assign dv_out   = r_dv_out;
  assign chan_out = r_chan_out;
  assign data_out = r_data_out;

endmodule
`default_nettype wire

// File: tb/tb_oversample_filter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : tb_oversample_filter                                    |
// | Brief  : Self-checking bench for oversample_filter: directed     |
// |          scenarios plus randomized traffic against a sample-     |
// |          level reference model of per-channel block averages.    |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module tb_oversample_filter;
  import oversample_filter_pkg::*;

  localparam int NCH    = 8;
  localparam int MAX_OS = 15;

  logic               clk_in = 1'b0;
  logic               rst_in;
  logic               dv_in;
  logic [4:0]         chan_in;
  logic signed [17:0] data_in;
  logic               wr_en;
  logic [15:0]        wr_addr;
  logic [15:0]        wr_chan;
  logic [47:0]        wr_data;
  logic               dv_out;
  logic [4:0]         chan_out;
  logic signed [17:0] data_out;

  oversample_filter dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .dv_in    (dv_in),
    .chan_in  (chan_in),
    .data_in  (data_in),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_chan  (wr_chan),
    .wr_data  (wr_data),
    .dv_out   (dv_out),
    .chan_out (chan_out),
    .data_out (data_out)
  );

  always #5 clk_in = ~clk_in;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state: per-channel sample list summary and ratio
  longint m_sum [NCH];
  int     m_cnt [NCH];
  int     m_os  [NCH];
  bit     pend_v;
  int     pend_ch;
  int     pend_d;
  bit     exp_dv;
  int     exp_chan;
  longint exp_data;
  longint obs_q [$];

  task automatic check(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic longint floor_div(input longint s, input longint n);
    longint q;
    q = s / n;
    if ((s % n != 0) && (s < 0)) q = q - 1;
    return q;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_sum[i] = 0;
      m_cnt[i] = 0;
      m_os[i]  = 0;
    end
    pend_v   = 1'b0;
    exp_dv   = 1'b0;
    exp_chan = 0;
    exp_data = 0;
  endtask

  // One clock: drive inputs, advance the model, then compare after the edge
  task automatic step(input bit rst, input bit dv, input int ch, input int d,
                      input bit we, input int wa, input int wc, input longint wd);
    bit clr;
    rst_in  = rst;
    dv_in   = dv;
    chan_in = 5'(ch);
    data_in = 18'(d);
    wr_en   = we;
    wr_addr = 16'(wa);
    wr_chan = 16'(wc);
    wr_data = 48'(wd);
    if (rst) begin
      model_reset();
    end else begin
      clr = we && (wc < NCH) &&
            ((wa == int'(OS_RATIO_ADDR)) || ((wa == int'(OS_CLR_RQST_ADDR)) && wd[0]));
      exp_dv = 1'b0;
      // sample taken last cycle is added now unless its channel is cleared now
      if (pend_v && !(clr && (wc == pend_ch))) begin
        m_sum[pend_ch] += pend_d;
        m_cnt[pend_ch] += 1;
        if (m_cnt[pend_ch] == (1 << m_os[pend_ch])) begin
          exp_dv   = 1'b1;
          exp_chan = pend_ch;
          exp_data = floor_div(m_sum[pend_ch], longint'(1) << m_os[pend_ch]);
          m_sum[pend_ch] = 0;
          m_cnt[pend_ch] = 0;
        end
      end
      if (clr) begin
        m_sum[wc] = 0;
        m_cnt[wc] = 0;
        if (wa == int'(OS_RATIO_ADDR)) m_os[wc] = (wd > MAX_OS) ? MAX_OS : int'(wd);
      end
      pend_v  = dv && (ch < NCH) && !(clr && (wc == ch));
      pend_ch = ch;
      pend_d  = d;
    end
    @(posedge clk_in);
    #1;
    check("dv_out", longint'(dv_out), longint'(exp_dv));
    check("chan_out", longint'(chan_out), longint'(exp_chan));
    check("data_out", longint'(data_out), exp_data);
    if (dv_out === 1'b1) obs_q.push_back(longint'(data_out));
  endtask

  task automatic smp(input int ch, input int d);
    step(1'b0, 1'b1, ch, d, 1'b0, 0, 0, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, 1'b0, 0, 0, 0);
  endtask

  task automatic hw(input int wa, input int wc, input longint wd);
    step(1'b0, 1'b0, 0, 0, 1'b1, wa, wc, wd);
  endtask

  task automatic pulse_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 0, 55, 1'b0, 0, 0, 0);
  endtask

  function automatic longint q_at(input int i);
    return (obs_q.size() > i) ? obs_q[i] : -999999;
  endfunction

  initial begin
    model_reset();
    pulse_reset(2);

    // 1: pass-through, exact 2-cycle latency on consecutive samples
    obs_q.delete();
    smp(0, 100);
    smp(0, -5);
    idle(3);
    check("t1_count", obs_q.size(), 2);
    check("t1_first", q_at(0), 100);
    check("t1_second", q_at(1), -5);

    // 2: ratio 4 on ch3, positive then negative floor
    obs_q.delete();
    hw(int'(OS_RATIO_ADDR), 3, 2);
    for (int i = 0; i < 4; i++) smp(3, 10 + i);
    idle(3);
    smp(3, -1); smp(3, -1); smp(3, -1); smp(3, -2);
    idle(3);
    check("t2_count", obs_q.size(), 2);
    check("t2_avg_pos", q_at(0), 11);
    check("t2_avg_floor_neg", q_at(1), -2);

    // 3: back-to-back same channel, then interleaved channels
    obs_q.delete();
    hw(int'(OS_RATIO_ADDR), 1, 1);
    hw(int'(OS_RATIO_ADDR), 2, 1);
    smp(1, 1); smp(1, 3); smp(1, 5); smp(1, 7);
    smp(1, 1); smp(2, 1); smp(1, 3); smp(2, 3);
    idle(3);
    check("t3_count", obs_q.size(), 4);
    check("t3_b2b_0", q_at(0), 2);
    check("t3_b2b_1", q_at(1), 6);
    check("t3_ilv_ch1", q_at(2), 2);
    check("t3_ilv_ch2", q_at(3), 2);

    // 4: clear discards partial block; clear kills in-flight samples
    obs_q.delete();
    hw(int'(OS_RATIO_ADDR), 5, 3);
    for (int i = 0; i < 5; i++) smp(5, 1000);
    hw(int'(OS_CLR_RQST_ADDR), 5, 1);
    for (int i = 0; i < 8; i++) smp(5, 8);
    idle(3);
    check("t4_count", obs_q.size(), 1);
    check("t4_avg", q_at(0), 8);
    obs_q.delete();
    hw(int'(OS_RATIO_ADDR), 5, 0);
    smp(5, 77);
    hw(int'(OS_CLR_RQST_ADDR), 5, 1);
    step(1'b0, 1'b1, 5, 66, 1'b1, int'(OS_CLR_RQST_ADDR), 5, 1);
    idle(3);
    check("t4_killed", obs_q.size(), 0);
    smp(5, 9);
    smp(9, 1234);
    idle(3);
    check("t4_after_kill", obs_q.size(), 1);
    check("t4_after_kill_val", q_at(0), 9);

    // 6: reset mid-block, then a fresh full block
    obs_q.delete();
    hw(int'(OS_RATIO_ADDR), 0, 2);
    smp(0, 100); smp(0, 200); smp(0, 300);
    pulse_reset(2);
    hw(int'(OS_RATIO_ADDR), 0, 2);
    for (int i = 0; i < 4; i++) smp(0, 7);
    idle(3);
    check("t6_count", obs_q.size(), 1);
    check("t6_avg", q_at(0), 7);

    // 5: full-scale at maximum ratio; ratio request of 20 saturates to 15
    obs_q.delete();
    hw(int'(OS_RATIO_ADDR), 7, 20);
    for (int i = 0; i < 32768; i++) smp(7, 131071);
    idle(3);
    for (int i = 0; i < 32768; i++) smp(7, -131072);
    idle(3);
    check("t5_count", obs_q.size(), 2);
    check("t5_max_pos", q_at(0), 131071);
    check("t5_max_neg", q_at(1), -131072);

    // Randomized traffic with host writes, invalid channels and stray addresses
    pulse_reset(2);
    obs_q.delete();
    for (int c = 0; c < NCH; c++) hw(int'(OS_RATIO_ADDR), c, $urandom_range(0, 3));
    for (int n = 0; n < 4000; n++) begin
      bit     dv;
      bit     we;
      int     wa;
      int     wc;
      longint wd;
      dv = ($urandom_range(0, 3) != 0);
      we = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 2))
        0:       wa = int'(OS_RATIO_ADDR);
        1:       wa = int'(OS_CLR_RQST_ADDR);
        default: wa = 16'h1234;
      endcase
      wc = ($urandom_range(0, 15) == 0) ? 300 : $urandom_range(0, 9);
      wd = (wa == int'(OS_RATIO_ADDR)) ? longint'($urandom_range(0, 4)) : longint'($urandom_range(0, 1));
      step(1'b0, dv, $urandom_range(0, 9), int'($urandom_range(0, 262143)) - 131072, we, wa, wc, wd);
      if ($urandom_range(0, 1999) == 0) pulse_reset(1);
    end
    idle(3);
    check("rand_activity", longint'(obs_q.size() > 50), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
